alu_result_capture: RTL and testbench
=====================================

// Module: alu_result_capture
// PURPOSE
//  Z-stage directly downstream of the combinational ALU. Captures the ALU's {Zhigh,Zlow} pair into a 64-bit Z register.
//  Multiply/Divide results are captured only after a programmable settle delay, because those ALU paths are deep.
//  Holds HI/LO registers loaded from Z, and drives the selected register onto the datapath bus.
//  Reports busy/done to the control unit so it can stall across multi-cycle captures.
// PARAMETERS
//  MULDIV_WAIT  4   cycles between start and Z capture for Multiply/Divide (0 => treat as single-cycle)
//  OP_MUL       5'b01110  ALU_ctl encoding of Multiply
//  OP_DIV       5'b01111  ALU_ctl encoding of Divide
// PORTS
//  clk       in   1   system clock, all state on rising edge
//  clr       in   1   asynchronous, active-low reset
//  Zin       in   1   start capture of current ALU outputs (control step strobe)
//  ALU_ctl   in   5   ALU opcode presented with Zin
//  IncPC     in   1   ALU is in PC-increment mode (always single-cycle)
//  Zhigh_in  in   32  ALU Zhigh output
//  Zlow_in   in   32  ALU Zlow output
//  HIin      in   1   load HI <= Z[63:32]
//  LOin      in   1   load LO <= Z[31:0]
//  ZHighout  in   1   drive Z[63:32] on bus
//  ZLowout   in   1   drive Z[31:0] on bus
//  HIout     in   1   drive HI on bus
//  LOout     in   1   drive LO on bus
//  bus_out   out  32  selected register value, 0 when none selected
//  bus_drive out  1   OR of the four *out selects
//  busy      out  1   capture in progress (WAIT state)
//  done      out  1   one-cycle pulse, cycle after Z is written
// BEHAVIOUR
//  Reset (clr=0, async): Z=0, HI=0, LO=0, state=IDLE, cnt=0, busy=0, done=0; bus_out=0 unless a select is high.
//  Reset mid-WAIT aborts the capture: no Z write, no done pulse.
//  FSM states:
//   IDLE: waiting for Zin.
//   WAIT: counting down the settle delay; busy=1 for every cycle in WAIT.
//  Slow op = (ALU_ctl==OP_MUL || ALU_ctl==OP_DIV) && !IncPC && MULDIV_WAIT!=0. Every other Zin is fast.
//  IDLE & Zin & fast: Z <= {Zhigh_in,Zlow_in} on that edge; done=1 for the next cycle; stay IDLE. Latency 1.
//  IDLE & Zin & slow: cnt <= MULDIV_WAIT; go to WAIT. Z is not written on this edge.
//  WAIT, each edge:
//   - if cnt>1: cnt <= cnt-1.
//   - if cnt==1: Z <= {Zhigh_in,Zlow_in}; go to IDLE; done=1 for the next cycle.
//   - Net effect: Z is written on the MULDIV_WAIT-th edge after the start edge.
//  Zin asserted while in WAIT is ignored: no queueing, no restart.
//  Upstream must hold the ALU operands and ALU_ctl stable throughout WAIT. This block does not re-check them.
//  Back-to-back fast captures are allowed, one per cycle; done stays high across consecutive captures.
//  HIin/LOin: on the edge, HI/LO load Z's value from before that edge. If a Z write happens on the same edge, HI/LO take the OLD Z.
//  HIin/LOin are honoured in any state; HIin and LOin together load both registers.
//  Bus read priority: ZHighout > ZLowout > HIout > LOout. bus_out is combinational from the registers.
//  bus_drive = ZHighout|ZLowout|HIout|LOout.
//  cnt width = $clog2(MULDIV_WAIT+1), minimum 1. No arithmetic on the data path: Z is a straight 64-bit copy.
// TESTING
//  Fast path: clr pulse; ALU_ctl=5'b00011, Zhigh_in=0, Zlow_in=32'h0000_0007, Zin 1 cycle
//   -> Z=64'h7 after the edge; done=1 next cycle; ZLowout -> bus_out=7.
//  Slow path, MULDIV_WAIT=4: ALU_ctl=OP_MUL, {Zhigh_in,Zlow_in}=64'h0000_0001_FFFF_FFFE, Zin
//   -> busy=1 for 4 cycles; Z written on the 4th edge; single done pulse; ZHighout -> bus_out=1.
//  IncPC override: ALU_ctl=OP_DIV, IncPC=1, Zlow_in=32'h0000_0011, Zin -> fast capture, busy stays 0.
//  Abort: start slow capture; drive clr=0 during WAIT cycle 2
//   -> Z=0, busy=0, no done pulse; a later fast Zin captures normally.
//  Same-edge HI/LO: Z=64'hAAAA_AAAA_5555_5555; fast Zin with new value 64'h1 together with HIin & LOin
//   -> HI=32'hAAAA_AAAA, LO=32'h5555_5555, Z=1.
//  Bus priority: ZLowout & HIout both high -> bus_out=Z[31:0], bus_drive=1; no selects -> bus_out=0, bus_drive=0.

Source files
------------

// File: rtl/alu_result_capture_if.sv
// Z-stage interface: capture strobe, ALU result pair, HI/LO loads,
// bus read selects and the busy/done status back to control.
interface alu_result_capture_if;
   logic        Zin;
   logic [4:0]  ALU_ctl;
   logic        IncPC;
   logic [31:0] Zhigh_in;
   logic [31:0] Zlow_in;
   logic        HIin;
   logic        LOin;
   logic        ZHighout;
   logic        ZLowout;
   logic        HIout;
   logic        LOout;
   logic [31:0] bus_out;
   logic        bus_drive;
   logic        busy;
   logic        done;

   modport master (
      output Zin, ALU_ctl, IncPC, Zhigh_in, Zlow_in,
      output HIin, LOin, ZHighout, ZLowout, HIout, LOout,
      input  bus_out, bus_drive, busy, done
   );

   modport slave (
      input  Zin, ALU_ctl, IncPC, Zhigh_in, Zlow_in,
      input  HIin, LOin, ZHighout, ZLowout, HIout, LOout,
      output bus_out, bus_drive, busy, done
   );
endinterface

// File: rtl/alu_result_capture.sv
// Z-stage behind the combinational ALU: captures {Zhigh,Zlow} into Z,
// delaying Multiply/Divide captures by MULDIV_WAIT cycles so the deep
// ALU paths can settle. Holds HI/LO and muxes a register onto the bus.
module alu_result_capture #(
   parameter int unsigned MULDIV_WAIT = 4,
   parameter logic [4:0]  OP_MUL      = 5'b01110,
   parameter logic [4:0]  OP_DIV      = 5'b01111
) (
   input  logic                 clk,
   input  logic                 clr,
   alu_result_capture_if.slave  cap
);

   localparam int unsigned CW = (MULDIV_WAIT < 1) ? 1 : $clog2(MULDIV_WAIT + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_WAIT);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [63:0]   z;
   logic [31:0]   hi, lo;
   logic          done_q;
   logic          z_we;
   logic          slow_op;

   assign slow_op = ((cap.ALU_ctl == OP_MUL) || (cap.ALU_ctl == OP_DIV))
                    && !cap.IncPC && (MULDIV_WAIT != 0);

   // FSM state and settle counter register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state, counter update and Z write enable
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      z_we      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cap.Zin) begin
               if (slow_op) begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = CNT_LOAD;
               end else begin
                  z_we = 1'b1;
               end
            end
         end
         S_WAIT: begin
            // Zin is deliberately ignored here: no queueing, no restart
            if (cnt > CW'(1)) begin
               cnt_nxt = cnt - CW'(1);
            end else begin
               cnt_nxt   = '0;
               z_we      = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Data registers; HI/LO sample the pre-edge Z even when Z is written
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         z      <= '0;
         hi     <= '0;
         lo     <= '0;
         done_q <= 1'b0;
      end else begin
         if (z_we)     z  <= {cap.Zhigh_in, cap.Zlow_in};
         if (cap.HIin) hi <= z[63:32];
         if (cap.LOin) lo <= z[31:0];
         done_q <= z_we;
      end
   end

   // Status outputs and prioritised bus read mux
   always_comb begin
      cap.busy      = (state == S_WAIT);
      cap.done      = done_q;
      cap.bus_drive = cap.ZHighout | cap.ZLowout | cap.HIout | cap.LOout;
      if (cap.ZHighout)     cap.bus_out = z[63:32];
      else if (cap.ZLowout) cap.bus_out = z[31:0];
      else if (cap.HIout)   cap.bus_out = hi;
      else if (cap.LOout)   cap.bus_out = lo;
      else                  cap.bus_out = '0;
   end

endmodule

// File: tb/tb_alu_result_capture.sv
// Self-checking bench for alu_result_capture: directed scenarios plus
// randomized traffic, all compared against a transaction-level model.
module tb_alu_result_capture;

   localparam int unsigned W      = 4;
   localparam logic [4:0]  OP_MUL = 5'b01110;
   localparam logic [4:0]  OP_DIV = 5'b01111;
   localparam logic [4:0]  OP_ADD = 5'b00011;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   alu_result_capture_if cap();

   alu_result_capture #(.MULDIV_WAIT(W), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
      .clk (clk),
      .clr (clr),
      .cap (cap)
   );

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   // Reference model: register contents plus edges left until a pending
   // multiply/divide result lands in Z (0 = nothing pending)
   logic [63:0] m_z;
   logic [31:0] m_hi, m_lo;
   int unsigned m_left;
   bit          m_done;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_bus(input logic [3:0] sel);
      if (sel[3])      return m_z[63:32];
      else if (sel[2]) return m_z[31:0];
      else if (sel[1]) return m_hi;
      else if (sel[0]) return m_lo;
      else             return 32'h0;
   endfunction

   // Apply one cycle of inputs at the falling edge, check outputs, then
   // advance the model across the following rising edge.
   // sel = {ZHighout, ZLowout, HIout, LOout}
   task automatic step(input bit zin, input logic [4:0] ctl, input bit incpc,
                       input logic [63:0] zval, input bit hiin, input bit loin,
                       input logic [3:0] sel);
      logic [63:0] old_z;
      bit wr;
      @(negedge clk);
      cap.Zin = zin; cap.ALU_ctl = ctl; cap.IncPC = incpc;
      cap.Zhigh_in = zval[63:32]; cap.Zlow_in = zval[31:0];
      cap.HIin = hiin; cap.LOin = loin;
      {cap.ZHighout, cap.ZLowout, cap.HIout, cap.LOout} = sel;
      #1;
      check_eq("busy", {63'b0, cap.busy}, {63'b0, m_left != 0});
      check_eq("done", {63'b0, cap.done}, {63'b0, m_done});
      check_eq("bus_out", {32'b0, cap.bus_out}, {32'b0, model_bus(sel)});
      check_eq("bus_drive", {63'b0, cap.bus_drive}, {63'b0, sel != 4'b0});
      old_z = m_z;
      wr = 1'b0;
      if (m_left != 0) begin
         m_left--;
         wr = (m_left == 0);
      end else if (zin) begin
         if ((ctl == OP_MUL || ctl == OP_DIV) && !incpc && W != 0) m_left = W;
         else wr = 1'b1;
      end
      if (hiin) m_hi = old_z[63:32];
      if (loin) m_lo = old_z[31:0];
      if (wr)   m_z  = zval;
      m_done = wr;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      clr = 1'b0;
      cap.Zin = 1'b0; cap.ALU_ctl = '0; cap.IncPC = 1'b0;
      cap.Zhigh_in = '0; cap.Zlow_in = '0; cap.HIin = 1'b0; cap.LOin = 1'b0;
      {cap.ZHighout, cap.ZLowout, cap.HIout, cap.LOout} = 4'b0;
      m_z = '0; m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
      #1;
      check_eq("rst_busy", {63'b0, cap.busy}, 64'h0);
      check_eq("rst_done", {63'b0, cap.done}, 64'h0);
      check_eq("rst_bus", {32'b0, cap.bus_out}, 64'h0);
      check_eq("rst_drive", {63'b0, cap.bus_drive}, 64'h0);
      @(negedge clk);
      clr = 1'b1;
   endtask

   initial begin
      int unsigned nbusy, ndone;
      logic [63:0] hold_val;
      logic [4:0]  hold_ctl;
      bit          hold_inc;

      clr = 1'b1;
      apply_reset();

      // Fast path
      step(1, OP_ADD, 0, 64'h7, 0, 0, 4'b0000);
      step(0, OP_ADD, 0, 64'h0, 0, 0, 4'b0100);
      check_eq("fast_done", {63'b0, cap.done}, 64'h1);
      check_eq("fast_bus", {32'b0, cap.bus_out}, 64'h7);

      // Slow multiply: four busy cycles and a single done pulse
      nbusy = 0; ndone = 0;
      step(1, OP_MUL, 0, 64'h0000_0001_FFFF_FFFE, 0, 0, 4'b0000);
      for (int i = 0; i < 6; i++) begin
         step(i == 1, OP_MUL, 0, 64'h0000_0001_FFFF_FFFE, 0, 0, 4'b1000);
         nbusy += cap.busy;
         ndone += cap.done;
      end
      check_eq("slow_busy_cycles", 64'(nbusy), 64'd4);
      check_eq("slow_done_pulses", 64'(ndone), 64'd1);
      check_eq("slow_bus_hi", {32'b0, cap.bus_out}, 64'h1);

      // IncPC forces single-cycle even for Divide
      step(1, OP_DIV, 1, 64'h11, 0, 0, 4'b0000);
      step(0, OP_ADD, 0, 64'h0, 0, 0, 4'b0100);
      check_eq("incpc_busy", {63'b0, cap.busy}, 64'h0);
      check_eq("incpc_bus", {32'b0, cap.bus_out}, 64'h11);

      // Reset during WAIT cycle 2 aborts the capture
      step(1, OP_MUL, 0, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 4'b0000);
      step(0, OP_MUL, 0, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 4'b0000);
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         step(0, OP_MUL, 0, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 4'b1000);
         check_eq("abort_no_done", {63'b0, cap.done}, 64'h0);
         check_eq("abort_z_zero", {32'b0, cap.bus_out}, 64'h0);
      end
      step(1, OP_ADD, 0, 64'h1234, 0, 0, 4'b0000);
      step(0, OP_ADD, 0, 64'h0, 0, 0, 4'b0100);
      check_eq("after_abort_bus", {32'b0, cap.bus_out}, 64'h1234);

      // HI/LO load takes the old Z on a same-edge Z write
      step(1, OP_ADD, 0, 64'hAAAA_AAAA_5555_5555, 0, 0, 4'b0000);
      step(1, OP_ADD, 0, 64'h1, 1, 1, 4'b0000);
      step(0, OP_ADD, 0, 64'h0, 0, 0, 4'b0010);
      check_eq("same_edge_hi", {32'b0, cap.bus_out}, 64'hAAAA_AAAA);
      step(0, OP_ADD, 0, 64'h0, 0, 0, 4'b0001);
      check_eq("same_edge_lo", {32'b0, cap.bus_out}, 64'h5555_5555);
      step(0, OP_ADD, 0, 64'h0, 0, 0, 4'b0100);
      check_eq("same_edge_z", {32'b0, cap.bus_out}, 64'h1);

      // Bus priority
      step(0, OP_ADD, 0, 64'h0, 0, 0, 4'b0110);
      check_eq("prio_bus", {32'b0, cap.bus_out}, 64'h1);
      check_eq("prio_drive", {63'b0, cap.bus_drive}, 64'h1);
      step(0, OP_ADD, 0, 64'h0, 0, 0, 4'b0000);
      check_eq("none_bus", {32'b0, cap.bus_out}, 64'h0);
      check_eq("none_drive", {63'b0, cap.bus_drive}, 64'h0);

      // Randomized traffic; ALU inputs held stable while a capture is pending
      hold_val = '0; hold_ctl = OP_ADD; hold_inc = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (m_left == 0) begin
            hold_val = {$urandom, $urandom};
            case ($urandom_range(0, 4))
               0:       hold_ctl = OP_MUL;
               1:       hold_ctl = OP_DIV;
               default: hold_ctl = 5'($urandom);
            endcase
            hold_inc = ($urandom_range(0, 5) == 0);
         end
         step($urandom_range(0, 1) == 1, hold_ctl, hold_inc, hold_val,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 4'($urandom));
      end
      step(0, OP_ADD, 0, 64'h0, 0, 0, 4'b0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
